// File: rtl/piso_pkg.sv
// Shared types and frame-length helper for the piso4_tx serialiser.
// Frame length depends on the PISO_TX_PARITY_EN build macro.
package piso_pkg;

    typedef enum logic {
        st_idle  = 1'b0,
        st_shift = 1'b1
    } state_t;

    function automatic int unsigned frame_len(input int unsigned width);
`ifdef PISO_TX_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/piso4_tx.sv
// Parallel-in serial-out transmitter with valid/ready load and gapless streaming.
// Build macro PISO_TX_PARITY_EN appends an even-parity bit to every frame.
module piso4_tx
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i,
    input  logic             i_valid,
    output logic             i_ready,
    output logic             so,
    output logic             so_valid,
    output logic             so_last,
    output logic             busy
);

    localparam int unsigned FL = frame_len(WIDTH);
    localparam int unsigned CW = $clog2(FL + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(FL - 1);

    state_t          r_state, w_state_nxt;
    logic [FL-1:0]   r_sr, w_sr_nxt, w_frame;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_ready, w_ready_nxt;
    logic            r_so, w_so_nxt;
    logic            r_so_last, w_so_last_nxt;
    logic            w_accept;
    logic            w_load;

    assign w_accept = i_valid && r_ready;

    // Frame laid out in transmit order: the bit at FL-1 goes out first.
    always_comb begin
        w_frame = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            w_frame[FL-1-k] = LSB_FIRST ? i[k] : i[WIDTH-1-k];
        end
`ifdef PISO_TX_PARITY_EN
        w_frame[0] = ^i;
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        w_so_nxt    = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            st_idle: begin
                if (w_accept) begin
                    w_load = 1'b1;
                end
            end
            st_shift: begin
                if (r_cnt == LAST_CNT) begin
                    if (w_accept) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = st_idle;
                        w_cnt_nxt   = '0;
                        w_sr_nxt    = '0;
                    end
                end else begin
                    w_so_nxt  = r_sr[FL-1];
                    w_sr_nxt  = r_sr << 1;
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = st_idle;
                w_cnt_nxt   = '0;
            end
        endcase
        // First bit goes straight to the output flop; the rest queue in r_sr.
        if (w_load) begin
            w_state_nxt = st_shift;
            w_so_nxt    = w_frame[FL-1];
            w_sr_nxt    = w_frame << 1;
            w_cnt_nxt   = '0;
        end
        w_ready_nxt   = (w_state_nxt == st_idle) || (w_cnt_nxt == LAST_CNT);
        w_so_last_nxt = (w_state_nxt == st_shift) && (w_cnt_nxt == LAST_CNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= st_idle;
            r_sr      <= '0;
            r_cnt     <= '0;
            r_ready   <= 1'b0;
            r_so      <= 1'b0;
            r_so_last <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sr      <= w_sr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ready   <= w_ready_nxt;
            r_so      <= w_so_nxt;
            r_so_last <= w_so_last_nxt;
        end
    end

    assign i_ready  = r_ready;
    assign so       = r_so;
    assign so_valid = (r_state == st_shift);
    assign so_last  = r_so_last;
    assign busy     = (r_state == st_shift);

endmodule
